// File: rtl/bus_capture_reader.sv
// Receiving end of the gated 4-bit bus: settle, capture one word per enable, queue in a show-ahead FIFO.
// Optional abort counter output enabled with `define ABORT_CNT_EN.
module bus_capture_reader #(
    parameter int WIDTH      = 4,
    parameter int DEPTH      = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [WIDTH-1:0]           i_bus,
    input  logic                       i_bus_en,
    input  logic                       i_rd_rdy,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_rd_valid,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_ovf
`ifdef ABORT_CNT_EN
    ,
    output logic [3:0]                 o_abort_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] LP_SETTLE = 3'(SETTLE_CYC);
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_settle;
    logic [2:0]       w_settle_nxt;
    logic             r_bus_en_d;
    logic             w_rise;
    logic             w_push;
    logic             w_abort;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_wr;

    // Reset loads the live enable so a transfer already in progress is not seen as a new rise.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_settle   <= 3'd0;
            r_bus_en_d <= i_bus_en;
        end else begin
            r_state    <= w_next;
            r_settle   <= w_settle_nxt;
            r_bus_en_d <= i_bus_en;
        end
    end

    assign w_rise = i_bus_en & ~r_bus_en_d;

    always_comb begin
        w_next       = r_state;
        w_settle_nxt = r_settle;
        w_push       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_next       = S_SETTLE;
                    w_settle_nxt = 3'd1;
                end
            end
            S_SETTLE: begin
                if (!i_bus_en) begin
                    w_next       = S_IDLE;
                    w_settle_nxt = 3'd0;
                    w_abort      = 1'b1;
                end else if (r_settle == LP_SETTLE) begin
                    w_next = S_CAPTURE;
                end else begin
                    w_settle_nxt = r_settle + 3'd1;
                end
            end
            S_CAPTURE: begin
                w_settle_nxt = 3'd0;
                if (!i_bus_en) begin
                    w_next  = S_IDLE;
                    w_abort = 1'b1;
                end else begin
                    w_next = S_HOLD;
                    w_push = 1'b1;
                end
            end
            S_HOLD: begin
                if (!i_bus_en) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next       = S_IDLE;
                w_settle_nxt = 3'd0;
            end
        endcase
    end

    assign w_full  = (r_count == LP_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & i_rd_rdy;
    // A pop in the same cycle frees the slot for a push into a full FIFO.
    assign w_wr    = w_push & (~w_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (!i_reset && w_wr) begin
            r_mem[r_wptr] <= i_bus;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_rd_data  = w_empty ? '0 : r_mem[r_rptr];
    assign o_rd_valid = ~w_empty;
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_ovf      = r_ovf;

`ifdef ABORT_CNT_EN
    logic [3:0] r_abort_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_abort_cnt <= 4'd0;
        end else if (w_abort && r_abort_cnt != 4'hF) begin
            r_abort_cnt <= r_abort_cnt + 4'd1;
        end
    end

    assign o_abort_cnt = r_abort_cnt;
`else
    logic w_unused_abort;
    assign w_unused_abort = w_abort;
`endif

endmodule
